// File: rtl/multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_timer
// Purpose  : NUM_CH independent down-counting interval timers behind one
//            Avalon-MM slave port, per-channel IRQ plus OR-reduced irq.
//            Define MULTI_TIMER_PRESCALE_EN for the per-channel 8-bit prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_timer #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int RESET_PERIOD = 49999,
   parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [15:0]       writedata,
   output logic [15:0]       readdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              irq
);

   localparam int               HI_W     = CNT_W - 16;
   localparam logic [CNT_W-1:0] RST_VAL  = CNT_W'(RESET_PERIOD);
   localparam logic [ADDR_W-1:0] NUM_CH_A = ADDR_W'(NUM_CH);

   localparam logic [2:0] OFS_STATUS = 3'd0;
   localparam logic [2:0] OFS_CTRL   = 3'd1;
   localparam logic [2:0] OFS_PER_L  = 3'd2;
   localparam logic [2:0] OFS_PER_H  = 3'd3;
   localparam logic [2:0] OFS_SNAP_L = 3'd4;
   localparam logic [2:0] OFS_SNAP_H = 3'd5;
   localparam logic [2:0] OFS_PSC    = 3'd7;

   logic [ADDR_W-1:0] w_ch_idx;
   logic [2:0]        w_ofs;
   logic              w_wr;
   logic [15:0]       w_rd [NUM_CH];
   logic [15:0]       w_rdata;
   logic [15:0]       readdata_q;

   assign w_ch_idx = address >> 3;
   assign w_ofs    = address[2:0];
   assign w_wr     = chipselect && !write_n && (w_ch_idx < NUM_CH_A);

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d;
         logic [3:0]       ctrl_q, ctrl_d;
         logic             run_q, run_d, to_q, to_d;
         logic             zero_q, force_reload_q, force_reload_d;
         logic             w_sel, w_zero, w_tick, w_event, w_start;
         logic [15:0]      w_rd_ch;

         assign w_sel   = w_wr && (w_ch_idx == ADDR_W'(i));
         assign w_zero  = (cnt_q == '0);
         assign w_event = w_zero && !zero_q;
         assign w_start = w_sel && (w_ofs == OFS_CTRL) && writedata[2];

`ifdef MULTI_TIMER_PRESCALE_EN
         logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;

         assign w_tick = (pcnt_q == psc_q);

         always_comb begin
            psc_d  = psc_q;
            pcnt_d = pcnt_q;
            if (run_q) pcnt_d = w_tick ? 8'd0 : pcnt_q + 8'd1;
            if (force_reload_q || w_start || (w_sel && w_ofs == OFS_PSC)) pcnt_d = 8'd0;
            if (w_sel && w_ofs == OFS_PSC) psc_d = writedata[7:0];
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               psc_q  <= 8'd0;
               pcnt_q <= 8'd0;
            end else begin
               psc_q  <= psc_d;
               pcnt_q <= pcnt_d;
            end
         end
`else
         assign w_tick = 1'b1;
`endif

         // Priority, lowest first: counting, forced reload, bus write.
         always_comb begin
            cnt_d          = cnt_q;
            per_d          = per_q;
            snap_d         = snap_q;
            ctrl_d         = ctrl_q;
            run_d          = run_q;
            to_d           = to_q | w_event;
            force_reload_d = 1'b0;
            if (run_q && w_tick) begin
               if (w_zero) begin
                  cnt_d = per_q;
                  if (!ctrl_q[1]) run_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            if (force_reload_q) begin
               cnt_d = per_q;
               run_d = 1'b0;
            end
            if (w_sel) begin
               case (w_ofs)
                  OFS_STATUS: to_d = 1'b0;
                  OFS_CTRL: begin
                     ctrl_d = writedata[3:0];
                     if (writedata[3]) run_d = 1'b0;
                     if (writedata[2]) run_d = 1'b1;
                  end
                  OFS_PER_L: begin
                     per_d[15:0]    = writedata;
                     force_reload_d = 1'b1;
                  end
                  OFS_PER_H: begin
                     per_d[CNT_W-1:16] = writedata[HI_W-1:0];
                     force_reload_d    = 1'b1;
                  end
                  OFS_SNAP_L, OFS_SNAP_H: snap_d = cnt_q;
                  default: ;
               endcase
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q          <= RST_VAL;
               per_q          <= RST_VAL;
               snap_q         <= '0;
               ctrl_q         <= 4'd0;
               run_q          <= 1'b0;
               to_q           <= 1'b0;
               zero_q         <= 1'b0;
               force_reload_q <= 1'b0;
            end else begin
               cnt_q          <= cnt_d;
               per_q          <= per_d;
               snap_q         <= snap_d;
               ctrl_q         <= ctrl_d;
               run_q          <= run_d;
               to_q           <= to_d;
               zero_q         <= w_zero;
               force_reload_q <= force_reload_d;
            end
         end

         always_comb begin
            w_rd_ch = 16'd0;
            case (w_ofs)
               OFS_STATUS: w_rd_ch = {14'd0, run_q, to_q};
               OFS_CTRL:   w_rd_ch = {12'd0, ctrl_q};
               OFS_PER_L:  w_rd_ch = per_q[15:0];
               OFS_PER_H:  w_rd_ch[HI_W-1:0] = per_q[CNT_W-1:16];
               OFS_SNAP_L: w_rd_ch = snap_q[15:0];
               OFS_SNAP_H: w_rd_ch[HI_W-1:0] = snap_q[CNT_W-1:16];
`ifdef MULTI_TIMER_PRESCALE_EN
               OFS_PSC:    w_rd_ch = {8'd0, psc_q};
`else
               OFS_PSC:    w_rd_ch = 16'd0;
`endif
               default:    w_rd_ch = 16'd0;
            endcase
         end

         assign w_rd[i]    = w_rd_ch;
         assign irq_vec[i] = to_q && ctrl_q[0];
      end
   endgenerate

   always_comb begin
      w_rdata = 16'd0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_ch_idx == ADDR_W'(k)) w_rdata = w_rd[k];
      end
   end

   // Read data holds between reads; out-of-range channels decode to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= 16'd0;
      end else if (chipselect && write_n) begin
         readdata_q <= w_rdata;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |irq_vec;

endmodule
`default_nettype wire
